// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and width helpers for the UART receiver slice.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   // Receiver FSM state encoding
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } rx_state_t;

   // Width of a counter that must hold 0..data_bits (data bit index)
   function automatic int bit_idx_width(input int data_bits);
      return $clog2(data_bits + 1);
   endfunction

   // Width of a counter that must hold 0..oversample-1 (ticks within one bit)
   function automatic int sample_cnt_width(input int oversample);
      return (oversample > 1) ? $clog2(oversample) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running divider producing a one-cycle oversample tick
//               every CLKS_PER_TICK clocks (every cycle when CLKS_PER_TICK=1).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
   parameter int CLKS_PER_TICK = 27
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int c_CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_TICK - 1);

   logic [c_CW-1:0] r_cnt;

   // Divider counter wraps at the terminal count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_CW'(1);
      end
   end

   assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module      : uart_rx_core
// Description : Oversampling UART receiver. 2-FF synchroniser, mid-bit
//               sampling, false-start rejection, framing and optional parity
//               checks, single-word holding register with valid/ready and an
//               overrun pulse for words dropped while the held word is unread.
//               Optional feature macro: UART_RX_PARITY_EN (adds a parity bit
//               between data and stop; parity_err tied to 0 when undefined).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int OVERSAMPLE    = 16,
   parameter int CLKS_PER_TICK = 27,
   parameter int STOP_BITS     = 1,
   parameter int LSB_FIRST     = 1,
   parameter int PARITY_ODD    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int c_BIW  = bit_idx_width(DATA_BITS);
   localparam int c_SCW  = sample_cnt_width(OVERSAMPLE);
   localparam logic [c_SCW-1:0] c_MID  = c_SCW'(OVERSAMPLE/2 - 1);
   localparam logic [c_SCW-1:0] c_LAST = c_SCW'(OVERSAMPLE - 1);
   localparam logic [c_BIW-1:0] c_LAST_BIT = c_BIW'(DATA_BITS - 1);

   // ------------------------------------------------------------------
   // Parameter legality
   // ------------------------------------------------------------------
   generate
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_rx_core: DATA_BITS must be 5..9");
      end
      if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
         $error("uart_rx_core: OVERSAMPLE must be even and >= 8");
      end
      if (CLKS_PER_TICK < 1) begin : g_bad_clks_per_tick
         $error("uart_rx_core: CLKS_PER_TICK must be >= 1");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
         $error("uart_rx_core: STOP_BITS must be 1 or 2");
      end
      if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
         $error("uart_rx_core: PARITY_ODD must be 0 or 1");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   logic                 r_sync1;
   logic                 r_sync2;
   logic                 w_rxs;
   logic                 w_tick;
   logic                 w_mid;
   logic                 w_last_stop;
   logic                 w_ferr_now;
   logic                 w_par_err;
   logic [DATA_BITS-1:0] w_shift_next;

   rx_state_t            r_state;
   logic [c_SCW-1:0]     r_smp_cnt;
   logic [c_BIW-1:0]     r_bit_cnt;
   logic                 r_stop_cnt;
   logic                 r_ferr_acc;
   logic [DATA_BITS-1:0] r_shift;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bit;
`endif

   // ------------------------------------------------------------------
   // Oversample tick generator
   // ------------------------------------------------------------------
   uart_baud_tick #(
      .CLKS_PER_TICK (CLKS_PER_TICK)
   ) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Two-flop synchroniser; resets to the idle line level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs = r_sync2;

   // Tick position within the current bit; held at 0 while waiting for a start edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_smp_cnt <= '0;
      end else if (w_tick) begin
         if (r_state == IDLE || r_state == WAIT_IDLE) begin
            r_smp_cnt <= '0;
         end else if (r_smp_cnt == c_LAST) begin
            r_smp_cnt <= '0;
         end else begin
            r_smp_cnt <= r_smp_cnt + c_SCW'(1);
         end
      end
   end

   assign w_mid       = w_tick && (r_smp_cnt == c_MID);
   assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
   assign w_ferr_now  = r_ferr_acc | ~w_rxs;

   // Shift direction decides which end of the word the first bit lands in
   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign w_shift_next = {w_rxs, r_shift[DATA_BITS-1:1]};
      end else begin : g_msb_first
         assign w_shift_next = {r_shift[DATA_BITS-2:0], w_rxs};
      end
   endgenerate

`ifdef UART_RX_PARITY_EN
   assign w_par_err = (((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD));
`else
   assign w_par_err = 1'b0;
`endif

   // Frame FSM plus output holding register, handshake and overrun pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= WAIT_IDLE;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_ferr_acc <= 1'b0;
         r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
         r_par_bit  <= 1'b0;
`endif
         data       <= '0;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         // Consumer handshake; a delivery in the same cycle overrides this
         if (valid && ready) begin
            valid <= 1'b0;
         end

         case (r_state)
            WAIT_IDLE: begin
               if (w_tick && w_rxs) begin
                  r_state <= IDLE;
               end
            end

            IDLE: begin
               if (w_tick && !w_rxs) begin
                  r_state <= START;
               end
            end

            START: begin
               if (w_mid) begin
                  if (w_rxs) begin
                     // Glitch shorter than half a bit: ignore silently
                     r_state <= IDLE;
                  end else begin
                     r_state   <= DATA;
                     r_bit_cnt <= '0;
                  end
               end
            end

            DATA: begin
               if (w_mid) begin
                  r_shift   <= w_shift_next;
                  r_bit_cnt <= r_bit_cnt + c_BIW'(1);
                  if (r_bit_cnt == c_LAST_BIT) begin
                     r_stop_cnt <= 1'b0;
                     r_ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     r_state    <= PARITY;
`else
                     r_state    <= STOP;
`endif
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (w_mid) begin
                  r_par_bit <= w_rxs;
                  r_state   <= STOP;
               end
            end
`endif

            STOP: begin
               if (w_mid) begin
                  if (w_last_stop) begin
                     if (!valid || ready) begin
                        data       <= r_shift;
                        frame_err  <= w_ferr_now;
                        parity_err <= w_par_err;
                        valid      <= 1'b1;
                     end else begin
                        overrun    <= 1'b1;
                     end
                     // A low final stop sample may be a break: wait for idle
                     r_state <= w_rxs ? IDLE : WAIT_IDLE;
                  end else begin
                     r_ferr_acc <= w_ferr_now;
                     r_stop_cnt <= 1'b1;
                  end
               end
            end

            default: begin
               r_state <= WAIT_IDLE;
            end
         endcase
      end
   end

   assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Directed self-checking bench for uart_rx_core, 8N1 with
//               CLKS_PER_TICK=1 and OVERSAMPLE=16 (one bit = 16 clk).
//               With UART_RX_PARITY_EN defined, frames carry an even parity bit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
   localparam int c_PRE_STOP = 10;
`else
   localparam int c_PRE_STOP = 9;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic       ready;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   int         ovr_cycles = 0;
   logic [7:0] acc_q[$];

   always #5 clk = ~clk;

   uart_rx_core #(
      .DATA_BITS     (8),
      .OVERSAMPLE    (16),
      .CLKS_PER_TICK (1),
      .STOP_BITS     (1),
      .LSB_FIRST     (1),
      .PARITY_ODD    (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   // Log overrun cycles and accepted words, sampled mid-cycle
   always begin
      @(negedge clk);
      #1;
      if (overrun === 1'b1) ovr_cycles++;
      if (valid === 1'b1 && ready === 1'b1) acc_q.push_back(data);
   end

   // Absolute runaway guard
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (16) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rxd = ^b;
      repeat (16) @(negedge clk);
`endif
      rxd = stop_v;
      repeat (16) @(negedge clk);
   endtask

   task automatic accept_word();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rxd = 1'b1; ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", data); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b want 1", busy); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_to_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      int n = 0;
      send_frame(8'hA5, 1'b1);
      rxd = 1'b1;
      while (valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", valid); end
      checks++; if (data !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h want a5", data); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_frame_err: got %b want 0", frame_err); end
      checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL basic_parity_err: got %b want 0", parity_err); end
      repeat (20) @(negedge clk);
      checks++; if (valid !== 1'b1 || data !== 8'hA5) begin failures++; $display("FAIL basic_hold: got valid=%b data=%h want 1/a5", valid, data); end
      accept_word();
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_drop_after_ready: got %b want 0", valid); end
      checks++; if (data !== 8'hA5) begin failures++; $display("FAIL basic_data_after_accept: got %h want a5", data); end
   endtask

   task automatic test_false_start();
      logic saw_busy = 1'b0;
      logic saw_valid = 1'b0;
      int   n = 0;
      rxd = 1'b0;
      repeat (4) begin @(negedge clk); if (busy === 1'b1) saw_busy = 1'b1; end
      rxd = 1'b1;
      while (busy !== 1'b0 && n < 16) begin
         @(negedge clk); n++;
         saw_busy = 1'b1;
         if (valid === 1'b1) saw_valid = 1'b1;
      end
      checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL false_start_detect: busy seen %b want 1", saw_busy); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL false_start_busy_release: got %b want 0 within 16 clk", busy); end
      repeat (40) begin @(negedge clk); if (valid === 1'b1) saw_valid = 1'b1; end
      checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL false_start_no_valid: valid seen %b want 0", saw_valid); end
   endtask

   task automatic test_frame_error();
      int ovr0 = ovr_cycles;
      send_frame(8'h3C, 1'b0);
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL ferr_valid: got %b want 1", valid); end
      checks++; if (data !== 8'h3C) begin failures++; $display("FAIL ferr_data: got %h want 3c", data); end
      checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
      // Long break: a restarted frame would complete here and overrun
      repeat (184) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_idle_busy: got %b want 1", busy); end
      checks++; if (ovr_cycles - ovr0 !== 0) begin failures++; $display("FAIL ferr_no_restart: overrun cycles %0d want 0", ovr_cycles - ovr0); end
      checks++; if (data !== 8'h3C || frame_err !== 1'b1) begin failures++; $display("FAIL ferr_word_kept: got data=%h ferr=%b want 3c/1", data, frame_err); end
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_recover_busy: got %b want 0", busy); end
      accept_word();
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ferr_accept: got %b want 0", valid); end
   endtask

   task automatic test_back_to_back();
      int ovr0 = ovr_cycles;
      int n0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (20) @(negedge clk);
      checks++; if (valid !== 1'b1 || data !== 8'h11) begin failures++; $display("FAIL b2b_kept_first: got valid=%b data=%h want 1/11", valid, data); end
      checks++; if (ovr_cycles - ovr0 !== 1) begin failures++; $display("FAIL b2b_overrun_pulse: got %0d cycles want 1", ovr_cycles - ovr0); end
      accept_word();
      checks++; if (acc_q.size() == 0 || acc_q[acc_q.size()-1] !== 8'h11) begin failures++; $display("FAIL b2b_accept_first: got %0d words want last 11", acc_q.size()); end

      ovr0 = ovr_cycles;
      n0   = acc_q.size();
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (c_PRE_STOP*16 + 4) @(negedge clk);
            ready = 1'b1;
         end
      join
      repeat (4) @(negedge clk);
      ready = 1'b0;
      checks++; if (ovr_cycles - ovr0 !== 0) begin failures++; $display("FAIL b2b_ready_no_overrun: got %0d cycles want 0", ovr_cycles - ovr0); end
      checks++; if (acc_q.size() - n0 !== 2) begin failures++; $display("FAIL b2b_ready_count: got %0d words want 2", acc_q.size() - n0); end
      else begin
         checks++; if (acc_q[n0] !== 8'h11 || acc_q[n0+1] !== 8'h22) begin failures++; $display("FAIL b2b_ready_order: got %h,%h want 11,22", acc_q[n0], acc_q[n0+1]); end
      end
      checks++; if (data !== 8'h22) begin failures++; $display("FAIL b2b_ready_data: got %h want 22", data); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_parity_frame(input logic [7:0] b, input logic par);
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (16) @(negedge clk);
      end
      rxd = par;
      repeat (16) @(negedge clk);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_parity();
      send_parity_frame(8'h07, 1'b1);
      checks++; if (valid !== 1'b1 || data !== 8'h07) begin failures++; $display("FAIL parity_good_word: got valid=%b data=%h want 1/07", valid, data); end
      checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL parity_good_flag: got %b want 0", parity_err); end
      accept_word();
      send_parity_frame(8'h07, 1'b0);
      checks++; if (valid !== 1'b1 || data !== 8'h07) begin failures++; $display("FAIL parity_bad_word: got valid=%b data=%h want 1/07", valid, data); end
      checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL parity_bad_flag: got %b want 1", parity_err); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL parity_bad_frame_err: got %b want 0", frame_err); end
      accept_word();
   endtask
`endif

   task automatic test_reset_midframe();
      logic [7:0] b = 8'h5A;
      logic       saw_valid = 1'b0;
      int         n = 0;
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = b[i];
         repeat (16) @(negedge clk);
      end
      rxd = b[4];
      repeat (8) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %h want 00", data); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", valid); end
      checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL midrst_flags: got fe=%b pe=%b ov=%b want 0/0/0", frame_err, parity_err, overrun); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy: got %b want 1", busy); end
      rxd = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (200) begin @(negedge clk); if (valid === 1'b1) saw_valid = 1'b1; end
      checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_partial: valid seen %b want 0", saw_valid); end
      send_frame(8'h5A, 1'b1);
      rxd = 1'b1;
      while (valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++; if (valid !== 1'b1 || data !== 8'h5A) begin failures++; $display("FAIL midrst_recover: got valid=%b data=%h want 1/5a", valid, data); end
      accept_word();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_frame_error();
      test_back_to_back();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
